// File: rtl/adc_seq_pkg.sv
// Shared types and defaults for the ADC capture sequencer.
// Contents:
//   seq_state_e  - sequencer state codes, visible on sts_state
//   trig_src_e   - trigger source selection
//   *_DEFAULT    - default widths for ADC samples, lengths and decimation
//   is_crossing  - true for the level-crossing trigger sources
package adc_seq_pkg;

    localparam int ADC_W_DEFAULT = 14;
    localparam int LEN_W_DEFAULT = 24;
    localparam int DEC_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HOLDOFF   = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_DONE      = 3'd4
    } seq_state_e;

    typedef enum logic [1:0] {
        TRIG_SW   = 2'd0,
        TRIG_RISE = 2'd1,
        TRIG_FALL = 2'd2,
        TRIG_EXT  = 2'd3
    } trig_src_e;

    // Crossing sources trigger on a decimated sample, which is itself
    // captured; the other sources start capture at the following strobe.
    function automatic logic is_crossing(trig_src_e src);
        return (src == TRIG_RISE) || (src == TRIG_FALL);
    endfunction

endpackage

// File: rtl/adc_trigger_detect.sv
// Trigger detection for the ADC capture sequencer.
// Ports:
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   arm_i           - forgets the previous decimated sample
//   strobe_i        - decimated sample strobe; sample_i is valid with it
//   sample_i        - channel A sample (signed)
//   level_i         - crossing threshold (signed)
//   src_i           - trigger source (trig_src_e encoding)
//   sw_trig_i       - software trigger pulse
//   ext_trig_i      - asynchronous external trigger
//   trig_o          - one-cycle trigger pulse for the selected source
module adc_trigger_detect
    import adc_seq_pkg::*;
#(
    parameter int ADC_W = ADC_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             arm_i,
    input  logic             strobe_i,
    input  logic [ADC_W-1:0] sample_i,
    input  logic [ADC_W-1:0] level_i,
    input  logic [1:0]       src_i,
    input  logic             sw_trig_i,
    input  logic             ext_trig_i,
    output logic             trig_o
);

    logic [ADC_W-1:0] prev_q, prev_d;
    logic             prev_valid_q, prev_valid_d;
    logic [2:0]       ext_sync_q;

    logic signed [ADC_W-1:0] cur_s, prev_s, lvl_s;
    logic rise_x, fall_x, ext_rise;

    assign cur_s  = $signed(sample_i);
    assign prev_s = $signed(prev_q);
    assign lvl_s  = $signed(level_i);

    // A crossing needs a previous decimated sample from the current arm.
    assign rise_x = strobe_i && prev_valid_q && (prev_s < lvl_s) && (cur_s >= lvl_s);
    assign fall_x = strobe_i && prev_valid_q && (prev_s > lvl_s) && (cur_s <= lvl_s);

    // Bits [1:0] are the two-flop synchronizer, bit 2 holds the last
    // synchronized level for edge detection.
    assign ext_rise = ext_sync_q[1] & ~ext_sync_q[2];

    always_comb begin
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        if (arm_i) begin
            prev_valid_d = 1'b0;
        end else if (strobe_i) begin
            prev_d       = sample_i;
            prev_valid_d = 1'b1;
        end
    end

    always_comb begin
        trig_o = 1'b0;
        case (trig_src_e'(src_i))
            TRIG_SW:   trig_o = sw_trig_i;
            TRIG_RISE: trig_o = rise_x;
            TRIG_FALL: trig_o = fall_x;
            TRIG_EXT:  trig_o = ext_rise;
            default:   trig_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            ext_sync_q   <= '0;
        end else begin
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            ext_sync_q   <= {ext_sync_q[1:0], ext_trig_i};
        end
    end

endmodule

// File: rtl/adc_capture_sequencer.sv
// Triggered, decimated dual-channel ADC capture with an AXI-Stream output.
// Ports:
//   ACLK, ARESETN           - clock, asynchronous active-low reset
//   adc_a, adc_b, adc_valid - signed sample pair and qualifier
//   cfg_*                   - arm/abort pulses and capture configuration,
//                             latched into shadow registers on arm
//   ext_trig                - asynchronous external trigger
//   m_axis_*                - one-deep output register, tdata={sext16(b),sext16(a)}
//   sts_*                   - state code, done, sticky overflow, sample count
module adc_capture_sequencer
    import adc_seq_pkg::*;
#(
    parameter int ADC_W = ADC_W_DEFAULT,
    parameter int LEN_W = LEN_W_DEFAULT,
    parameter int DEC_W = DEC_W_DEFAULT
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic [ADC_W-1:0] adc_a,
    input  logic [ADC_W-1:0] adc_b,
    input  logic             adc_valid,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic [1:0]       cfg_trig_src,
    input  logic [ADC_W-1:0] cfg_trig_level,
    input  logic             cfg_sw_trig,
    input  logic [LEN_W-1:0] cfg_holdoff,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [DEC_W-1:0] cfg_dec,
    input  logic             ext_trig,
    output logic [31:0]      m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic [2:0]       sts_state,
    output logic             sts_done,
    output logic             sts_overflow,
    output logic [LEN_W-1:0] sts_count
);

    seq_state_e       state_q, state_d;
    trig_src_e        src_q, src_d;
    logic [ADC_W-1:0] level_q, level_d;
    logic [LEN_W-1:0] holdoff_q, holdoff_d, len_q, len_d;
    logic [LEN_W-1:0] hold_cnt_q, hold_cnt_d, count_q, count_d;
    logic [DEC_W-1:0] dec_q, dec_d, dec_cnt_q, dec_cnt_d;
    logic [31:0]      tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic             done_q, done_d, ovf_q, ovf_d;

    logic             arm, strobe, accept, gen, is_last, trig;
    logic [LEN_W-1:0] len_eff;
    logic signed [15:0] a_ext, b_ext;

    assign arm     = cfg_start && !cfg_abort && (state_q == ST_IDLE || state_q == ST_DONE);
    assign strobe  = adc_valid && (dec_cnt_q == '0);
    assign accept  = tvalid_q && m_axis_tready;
    assign len_eff = (len_q == '0) ? LEN_W'(1) : len_q;
    assign is_last = (count_q == len_eff - 1'b1);
    assign a_ext   = 16'($signed(adc_a));
    assign b_ext   = 16'($signed(adc_b));

    adc_trigger_detect #(.ADC_W(ADC_W)) u_trig (
        .clk_i      (ACLK),
        .rst_ni     (ARESETN),
        .arm_i      (arm),
        .strobe_i   (strobe),
        .sample_i   (adc_a),
        .level_i    (level_q),
        .src_i      (src_q),
        .sw_trig_i  (cfg_sw_trig),
        .ext_trig_i (ext_trig),
        .trig_o     (trig)
    );

    // Next-state and datapath. Ordering matters: sample generation first,
    // then arm overrides it, and abort overrides everything.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        level_d    = level_q;
        holdoff_d  = holdoff_q;
        len_d      = len_q;
        dec_d      = dec_q;
        hold_cnt_d = hold_cnt_q;
        count_d    = count_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        done_d     = done_q;
        ovf_d      = ovf_q;
        dec_cnt_d  = dec_cnt_q;
        gen        = 1'b0;

        if (adc_valid) begin
            dec_cnt_d = (dec_cnt_q == dec_q) ? '0 : dec_cnt_q + 1'b1;
        end

        if (accept) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end

        case (state_q)
            ST_HOLDOFF: begin
                if (holdoff_q == '0) begin
                    state_d = ST_WAIT_TRIG;
                end else if (strobe) begin
                    if (hold_cnt_q == holdoff_q - 1'b1) state_d = ST_WAIT_TRIG;
                    else hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_WAIT_TRIG: begin
                if (trig) begin
                    state_d = ST_CAPTURE;
                    gen     = is_crossing(src_q);
                end
            end
            ST_CAPTURE: begin
                gen = strobe && (count_q < len_eff);
                if (accept && tlast_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_IDLE, ST_DONE: ;
            default: state_d = ST_IDLE;
        endcase

        // A sample arriving while the held beat is stalled is dropped; if it
        // was the final one, the held beat becomes the end of the packet.
        if (gen) begin
            count_d = (&count_q) ? count_q : count_q + 1'b1;
            if (tvalid_q && !m_axis_tready) begin
                ovf_d = 1'b1;
                if (is_last) tlast_d = 1'b1;
            end else begin
                tdata_d  = {b_ext, a_ext};
                tvalid_d = 1'b1;
                tlast_d  = is_last;
            end
        end

        if (arm) begin
            state_d    = ST_HOLDOFF;
            src_d      = trig_src_e'(cfg_trig_src);
            level_d    = cfg_trig_level;
            holdoff_d  = cfg_holdoff;
            len_d      = cfg_len;
            dec_d      = cfg_dec;
            hold_cnt_d = '0;
            dec_cnt_d  = '0;
            count_d    = '0;
            done_d     = 1'b0;
            ovf_d      = 1'b0;
            tvalid_d   = 1'b0;
            tlast_d    = 1'b0;
        end

        if (cfg_abort) begin
            state_d  = ST_IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            done_d   = done_q;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= ST_IDLE;
            src_q      <= TRIG_SW;
            level_q    <= '0;
            holdoff_q  <= '0;
            len_q      <= '0;
            dec_q      <= '0;
            hold_cnt_q <= '0;
            count_q    <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            dec_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            level_q    <= level_d;
            holdoff_q  <= holdoff_d;
            len_q      <= len_d;
            dec_q      <= dec_d;
            hold_cnt_q <= hold_cnt_d;
            count_q    <= count_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            dec_cnt_q  <= dec_cnt_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign sts_state     = state_q;
    assign sts_done      = done_q;
    assign sts_overflow  = ovf_q;
    assign sts_count     = count_q;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed self-checking bench for adc_capture_sequencer.
// Samples follow a = base + step*index, b = -a, where index 0 is the first
// valid cycle after the arm edge; accepted beats are logged by a monitor.
module tb_adc_capture_sequencer;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [13:0] adc_a, adc_b, cfg_trig_level;
    logic        adc_valid, cfg_start, cfg_abort, cfg_sw_trig, ext_trig;
    logic [1:0]  cfg_trig_src;
    logic [23:0] cfg_holdoff, cfg_len;
    logic [15:0] cfg_dec;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [2:0]  sts_state;
    logic        sts_done, sts_overflow;
    logic [23:0] sts_count;

    int checkCount = 0;
    int passCount  = 0;
    int sampleIdx  = 0;
    int aBase      = 0;
    int aStep      = 1;
    int beatCnt    = 0;
    logic [31:0] beatData [0:63];
    logic        beatLast [0:63];

    adc_capture_sequencer dut (
        .ACLK           (ACLK),
        .ARESETN        (ARESETN),
        .adc_a          (adc_a),
        .adc_b          (adc_b),
        .adc_valid      (adc_valid),
        .cfg_start      (cfg_start),
        .cfg_abort      (cfg_abort),
        .cfg_trig_src   (cfg_trig_src),
        .cfg_trig_level (cfg_trig_level),
        .cfg_sw_trig    (cfg_sw_trig),
        .cfg_holdoff    (cfg_holdoff),
        .cfg_len        (cfg_len),
        .cfg_dec        (cfg_dec),
        .ext_trig       (ext_trig),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .sts_state      (sts_state),
        .sts_done       (sts_done),
        .sts_overflow   (sts_overflow),
        .sts_count      (sts_count)
    );

    // Free-running clock
    always #5 ACLK = ~ACLK;

    // Beat logger: a beat is taken at the next rising edge when valid and ready
    always @(negedge ACLK) begin
        if (ARESETN && m_axis_tvalid && m_axis_tready && beatCnt < 64) begin
            beatData[beatCnt] = m_axis_tdata;
            beatLast[beatCnt] = m_axis_tlast;
            beatCnt = beatCnt + 1;
        end
    end

    // Safety net in case a bounded wait is itself broken
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %h required %h", tag, obs, exp);
    endtask

    task automatic setSample();
        int v;
        v = aBase + aStep * sampleIdx;
        adc_a = 14'(v);
        adc_b = 14'(-v);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
        sampleIdx++;
        setSample();
    endtask

    // Arms a capture, then scrambles the live cfg inputs so any leak past
    // the shadow registers shows up in the results.
    task automatic applyStimulus(input logic [1:0] src, input int level, input int dec,
                                 input int holdoff, input int len, input int base, input int step);
        cfg_trig_src   = src;
        cfg_trig_level = 14'(level);
        cfg_dec        = 16'(dec);
        cfg_holdoff    = 24'(holdoff);
        cfg_len        = 24'(len);
        cfg_start      = 1'b1;
        @(posedge ACLK);
        #1;
        cfg_start      = 1'b0;
        cfg_trig_src   = ~src;
        cfg_trig_level = 14'(level + 37);
        cfg_dec        = 16'd7;
        cfg_holdoff    = 24'd50;
        cfg_len        = 24'd99;
        aBase = base;
        aStep = step;
        sampleIdx = 0;
        setSample();
    endtask

    task automatic waitState(input string tag, input logic [2:0] target, input int budget);
        int n;
        n = 0;
        while (sts_state !== target && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(sts_state), 32'(target));
    endtask

    initial begin
        int b0;

        ARESETN = 1'b0;
        adc_valid = 1'b1;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        cfg_sw_trig = 1'b0;
        ext_trig = 1'b0;
        cfg_trig_src = 2'd0;
        cfg_trig_level = '0;
        cfg_holdoff = '0;
        cfg_len = '0;
        cfg_dec = '0;
        m_axis_tready = 1'b1;
        setSample();

        // Reset values
        repeat (3) @(posedge ACLK);
        #1;
        checkOutput("rst_state",  32'(sts_state), 32'd0);
        checkOutput("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("rst_tlast",  32'(m_axis_tlast), 32'd0);
        checkOutput("rst_tdata",  m_axis_tdata, 32'd0);
        checkOutput("rst_done",   32'(sts_done), 32'd0);
        checkOutput("rst_ovf",    32'(sts_overflow), 32'd0);
        checkOutput("rst_count",  32'(sts_count), 32'd0);
        ARESETN = 1'b1;
        tick();

        // Software trigger, no decimation or holdoff, four beats
        b0 = beatCnt;
        applyStimulus(2'd0, 0, 0, 0, 4, 100, 1);
        checkOutput("t1_holdoff", 32'(sts_state), 32'd1);
        tick();
        checkOutput("t1_wait", 32'(sts_state), 32'd2);
        cfg_sw_trig = 1'b1;
        tick();
        cfg_sw_trig = 1'b0;
        checkOutput("t1_capture", 32'(sts_state), 32'd3);
        tick();
        checkOutput("t1_tvalid", 32'(m_axis_tvalid), 32'd1);
        checkOutput("t1_tdata0", m_axis_tdata, 32'hFF9A0066);
        checkOutput("t1_count1", 32'(sts_count), 32'd1);
        waitState("t1_done_state", 3'd4, 20);
        checkOutput("t1_beats", 32'(beatCnt - b0), 32'd4);
        checkOutput("t1_beat3", beatData[b0 + 3], 32'hFF970069);
        checkOutput("t1_last0", 32'(beatLast[b0]), 32'd0);
        checkOutput("t1_last3", 32'(beatLast[b0 + 3]), 32'd1);
        checkOutput("t1_count", 32'(sts_count), 32'd4);
        checkOutput("t1_ovf", 32'(sts_overflow), 32'd0);
        checkOutput("t1_done", 32'(sts_done), 32'd1);

        // Rising crossing on a -100..+100 ramp, level 0
        b0 = beatCnt;
        applyStimulus(2'd1, 0, 0, 0, 3, -100, 1);
        waitState("t2_done_state", 3'd4, 150);
        checkOutput("t2_beats", 32'(beatCnt - b0), 32'd3);
        checkOutput("t2_a0", 32'(beatData[b0][15:0]), 32'd0);
        checkOutput("t2_a1", 32'(beatData[b0 + 1][15:0]), 32'd1);
        checkOutput("t2_beat2", beatData[b0 + 2], 32'hFFFE0002);
        checkOutput("t2_last2", 32'(beatLast[b0 + 2]), 32'd1);
        checkOutput("t2_count", 32'(sts_count), 32'd3);

        // Falling crossing, level 5, descending from 20: triggers on a == 5
        b0 = beatCnt;
        applyStimulus(2'd2, 5, 0, 0, 2, 20, -1);
        waitState("t3_done_state", 3'd4, 40);
        checkOutput("t3_beats", 32'(beatCnt - b0), 32'd2);
        checkOutput("t3_a0", 32'(beatData[b0][15:0]), 32'd5);
        checkOutput("t3_beat1", beatData[b0 + 1], 32'hFFFC0004);

        // Decimate by 4, discard two strobes, software trigger after index 8
        b0 = beatCnt;
        applyStimulus(2'd0, 0, 3, 2, 2, 0, 1);
        while (sampleIdx < 4) tick();
        checkOutput("t4_hold_at4", 32'(sts_state), 32'd1);
        tick();
        checkOutput("t4_wait_at5", 32'(sts_state), 32'd2);
        while (sampleIdx < 9) tick();
        checkOutput("t4_wait_at9", 32'(sts_state), 32'd2);
        cfg_sw_trig = 1'b1;
        tick();
        cfg_sw_trig = 1'b0;
        waitState("t4_done_state", 3'd4, 40);
        checkOutput("t4_beats", 32'(beatCnt - b0), 32'd2);
        checkOutput("t4_a0", 32'(beatData[b0][15:0]), 32'd12);
        checkOutput("t4_a1", 32'(beatData[b0 + 1][15:0]), 32'd16);
        checkOutput("t4_last1", 32'(beatLast[b0 + 1]), 32'd1);

        // Stalled sink: first sample held, the rest dropped, tlast moves to it
        m_axis_tready = 1'b0;
        b0 = beatCnt;
        applyStimulus(2'd0, 0, 0, 0, 5, 0, 1);
        tick();
        cfg_sw_trig = 1'b1;
        tick();
        cfg_sw_trig = 1'b0;
        tick();
        checkOutput("t5_count1", 32'(sts_count), 32'd1);
        checkOutput("t5_ovf_early", 32'(sts_overflow), 32'd0);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        checkOutput("t5_start_ignored", 32'(sts_state), 32'd3);
        checkOutput("t5_count2", 32'(sts_count), 32'd2);
        while (sampleIdx < 7) tick();
        checkOutput("t5_tvalid", 32'(m_axis_tvalid), 32'd1);
        checkOutput("t5_held_a", 32'(m_axis_tdata[15:0]), 32'd2);
        checkOutput("t5_tlast", 32'(m_axis_tlast), 32'd1);
        checkOutput("t5_ovf", 32'(sts_overflow), 32'd1);
        checkOutput("t5_count5", 32'(sts_count), 32'd5);
        m_axis_tready = 1'b1;
        waitState("t5_done_state", 3'd4, 5);
        checkOutput("t5_beats", 32'(beatCnt - b0), 32'd1);
        checkOutput("t5_done", 32'(sts_done), 32'd1);

        // Abort from DONE leaves sts_done alone
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        checkOutput("t6_idle", 32'(sts_state), 32'd0);
        checkOutput("t6_done_kept", 32'(sts_done), 32'd1);

        // Abort during capture with a held beat; abort beats a same-cycle start
        m_axis_tready = 1'b0;
        applyStimulus(2'd0, 0, 0, 0, 5, 0, 1);
        tick();
        cfg_sw_trig = 1'b1;
        tick();
        cfg_sw_trig = 1'b0;
        tick();
        tick();
        checkOutput("t7_tvalid", 32'(m_axis_tvalid), 32'd1);
        checkOutput("t7_ovf", 32'(sts_overflow), 32'd1);
        cfg_abort = 1'b1;
        cfg_start = 1'b1;
        tick();
        cfg_abort = 1'b0;
        cfg_start = 1'b0;
        checkOutput("t7_abort_idle", 32'(sts_state), 32'd0);
        checkOutput("t7_abort_tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("t7_abort_done", 32'(sts_done), 32'd0);
        applyStimulus(2'd0, 0, 0, 0, 5, 0, 1);
        checkOutput("t7_rearm_state", 32'(sts_state), 32'd1);
        checkOutput("t7_rearm_ovf", 32'(sts_overflow), 32'd0);
        checkOutput("t7_rearm_count", 32'(sts_count), 32'd0);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;

        // External trigger: 3-cycle pulse, two synchronizer stages plus edge
        m_axis_tready = 1'b1;
        b0 = beatCnt;
        applyStimulus(2'd3, 0, 0, 0, 2, 0, 1);
        tick();
        checkOutput("t8_wait", 32'(sts_state), 32'd2);
        ext_trig = 1'b1;
        tick();
        checkOutput("t8_sync1", 32'(sts_state), 32'd2);
        tick();
        checkOutput("t8_sync2", 32'(sts_state), 32'd2);
        tick();
        ext_trig = 1'b0;
        checkOutput("t8_capture", 32'(sts_state), 32'd3);
        waitState("t8_done_state", 3'd4, 20);
        repeat (10) tick();
        checkOutput("t8_beats", 32'(beatCnt - b0), 32'd2);
        checkOutput("t8_a0", 32'(beatData[b0][15:0]), 32'd4);
        checkOutput("t8_a1", 32'(beatData[b0 + 1][15:0]), 32'd5);
        checkOutput("t8_still_done", 32'(sts_state), 32'd4);

        // Reset in the middle of a stalled capture
        m_axis_tready = 1'b0;
        applyStimulus(2'd0, 0, 0, 0, 4, 0, 1);
        tick();
        cfg_sw_trig = 1'b1;
        tick();
        cfg_sw_trig = 1'b0;
        tick();
        checkOutput("t9_tvalid_pre", 32'(m_axis_tvalid), 32'd1);
        #2;
        ARESETN = 1'b0;
        #1;
        checkOutput("t9_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("t9_rst_tlast", 32'(m_axis_tlast), 32'd0);
        checkOutput("t9_rst_tdata", m_axis_tdata, 32'd0);
        checkOutput("t9_rst_state", 32'(sts_state), 32'd0);
        checkOutput("t9_rst_count", 32'(sts_count), 32'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        m_axis_tready = 1'b1;
        repeat (3) tick();
        checkOutput("t9_post_state", 32'(sts_state), 32'd0);
        checkOutput("t9_post_tvalid", 32'(m_axis_tvalid), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/adc_capture_sequencer.md
ADC_CAPTURE_SEQUENCER -- requirements
Module: adc_capture_sequencer

Interface
REQ-001 Parameter ADC_W, default 14, signed ADC sample width per channel.
REQ-002 Parameter LEN_W, default 24, width of capture length and holdoff counters.
REQ-003 Parameter DEC_W, default 16, width of decimation ratio.
REQ-004 ACLK  in  1  single clock; all logic rising-edge.
REQ-005 ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-006 adc_a, adc_b  in  ADC_W each  signed samples, one new pair every cycle adc_valid=1.
REQ-007 adc_valid  in  1  sample pair qualifier.
REQ-008 cfg_start  in  1  one-cycle arm pulse; cfg_abort  in  1  one-cycle abort pulse.
REQ-009 cfg_trig_src  in  2  0=software, 1=chA rising crossing, 2=chA falling crossing, 3=external.
REQ-010 cfg_trig_level  in  ADC_W  signed crossing threshold; cfg_sw_trig  in  1  software trigger pulse.
REQ-011 cfg_holdoff  in  LEN_W  decimated samples discarded after arm; cfg_len  in  LEN_W  samples to capture.
REQ-012 cfg_dec  in  DEC_W  keep one sample in cfg_dec+1; ext_trig  in  1  asynchronous external trigger.
REQ-013 m_axis_tdata  out  32  {sext16(b), sext16(a)}; m_axis_tvalid  out  1; m_axis_tready  in  1; m_axis_tlast  out  1.
REQ-014 sts_state  out  3  current state code; sts_done  out  1; sts_overflow  out  1; sts_count  out  LEN_W  samples generated.

Function
REQ-015 States IDLE(0), HOLDOFF(1), WAIT_TRIG(2), CAPTURE(3), DONE(4); encoding on sts_state.
REQ-016 cfg_* sampled into shadow registers on cfg_start; changes after arm have no effect until next arm.
REQ-017 IDLE or DONE + cfg_start -> HOLDOFF; clears sts_done, sts_overflow, sts_count, decimation counter; cfg_start ignored in HOLDOFF/WAIT_TRIG/CAPTURE.
REQ-018 Decimator: counts adc_valid cycles 0..dec; strobe when count=0, then wraps; dec=0 -> strobe every valid cycle.
REQ-019 HOLDOFF: discard holdoff strobes, then WAIT_TRIG; holdoff=0 -> WAIT_TRIG next cycle.
REQ-020 Rising crossing: previous decimated a < level and current a >= level; falling: previous a > level and current a <= level; first strobe after arm never triggers.
REQ-021 External: ext_trig double-flop synchronized, rising edge detected; software: cfg_sw_trig pulse; only honoured in WAIT_TRIG.
REQ-022 Trigger -> CAPTURE; for crossing sources the triggering sample is sample 0; for software/external the next strobe is sample 0.
REQ-023 CAPTURE: each strobe loads the one-deep output register, sts_count+1; len=0 treated as 1.
REQ-024 Strobe while tvalid=1 and tready=0: sample dropped, sts_overflow set (sticky until next arm), sts_count still increments.
REQ-025 tvalid stays high until tready; tdata/tlast stable while tvalid=1 and tready=0.
REQ-026 tlast=1 on sample with sts_count=len-1 (sample index len-1); if that sample dropped, tlast moves to the held sample.
REQ-027 CAPTURE -> DONE when final sample accepted (tvalid&tready); latency strobe-to-tvalid 1 cycle; sts_done=1 in DONE.
REQ-028 cfg_abort in any state -> IDLE next cycle, tvalid cleared, sts_done unchanged; abort and start same cycle: abort wins.
REQ-029 sts_count saturates at all-ones (no wrap).

Reset
REQ-030 ARESETN low: state IDLE, m_axis_tvalid=0, tlast=0, tdata=0, sts_done=0, sts_overflow=0, sts_count=0, synchronizers and decimator 0.
REQ-031 Reset mid-capture discards held sample; no tlast emitted.

Structure
REQ-032 Package adc_seq_pkg holds state enum, trig_src enum, ADC_W/LEN_W/DEC_W defaults.
REQ-033 Sub-module adc_trigger_detect: crossing compare, ext synchronizer, edge detect; one-cycle trig pulse out.

Verification
REQ-034 dec=0, holdoff=0, sw trig, len=4, tready=1 -> 4 beats, tlast on 4th, DONE, sts_count=4, overflow=0.
REQ-035 Ramp a=-100..+100 step 1, level=0, rising, len=3 -> tdata a fields 0,1,2.
REQ-036 dec=3, holdoff=2, sw trig, len=2 -> first beat = 13th sample after arm (index 12), second index 16.
REQ-037 tready=0 throughout CAPTURE, len=5 -> only first sample held, overflow=1, tlast asserted on held beat, sts_count=5.
REQ-038 cfg_abort during CAPTURE with tvalid=1 -> IDLE next cycle, tvalid=0; new cfg_start re-arms with cleared status.
REQ-039 ext_trig pulse 3 cycles wide in WAIT_TRIG -> exactly one capture start, 2-cycle synchronizer latency.
